// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types for the video SRAM slot arbiter
package sram_arbiter_pkg;

  // Arbiter sequencing states; the encoding is private to the arbiter.
  typedef enum logic [2:0] {
    IDLE,
    READ_ADDR,
    READ_CAPTURE,
    WRITE_SETUP,
    WRITE_STROBE,
    WRITE_RELEASE
  } arb_state_t;

  // Default geometry of the video SRAM (9-bit X, 8-bit Y, 8-bit pixels).
  localparam int PW_ADDR_WIDTH = 17;
  localparam int PW_DATA_WIDTH = 8;

  // Pending-write FIFO entry; the producer packs {address, data} in this order.
  typedef struct packed {
    logic [PW_ADDR_WIDTH-1:0] address;
    logic [PW_DATA_WIDTH-1:0] data;
  } pending_write_t;

endpackage

// File: rtl/sram_slot_arbiter.sv
// rtl/sram_slot_arbiter.sv - time-sliced read/write arbiter for the single-port video SRAM
module sram_slot_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int X_WIDTH             = 9,
  parameter int Y_WIDTH             = 8,
  parameter int DATA_WIDTH          = 8,
  parameter int PIXELS_PER_SLOT     = 2,
  parameter int MAX_WRITES_PER_SLOT = 1
) (
  input  logic                                  clock,
  input  logic                                  resetN,
  input  logic                                  slotStart,
  input  logic [X_WIDTH-1:0]                    readXCoord,
  input  logic [Y_WIDTH-1:0]                    readYCoord,
  output logic [PIXELS_PER_SLOT*DATA_WIDTH-1:0] pixels,
  output logic                                  pixelsValid,
  input  logic [X_WIDTH+Y_WIDTH+DATA_WIDTH-1:0] writeQueueData,
  input  logic                                  writeQueueEmpty,
  output logic                                  writeQueueReadRequest,
  output logic [X_WIDTH+Y_WIDTH-1:0]            sramAddress,
  input  logic [DATA_WIDTH-1:0]                 sramDataIn,
  output logic [DATA_WIDTH-1:0]                 sramDataOut,
  output logic                                  sramDataOutEnable,
  output logic                                  sramOutputEnableN,
  output logic                                  sramWriteEnableN,
  output logic                                  busy,
  output logic                                  slotOverrun
);

  localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH;
  localparam logic [3:0] LAST_IDX      = 4'(PIXELS_PER_SLOT - 1);
  localparam logic [3:0] MAX_WRITES    = 4'(MAX_WRITES_PER_SLOT);
  localparam logic       WRITES_ENABLED = (MAX_WRITES_PER_SLOT > 0);

  arb_state_t           state;
  logic [2:0]           pixel_idx;
  logic [2:0]           write_count;
  logic [X_WIDTH-1:0]   x_lat;
  logic [Y_WIDTH-1:0]   y_lat;
  logic [DATA_WIDTH-1:0] pixel_q [PIXELS_PER_SLOT];

  logic [ADDR_WIDTH-1:0] head_address;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  capture_now;
  logic                  more_writes;

  // FIFO head is show-ahead: address sits above data.
  assign head_address = writeQueueData[DATA_WIDTH +: ADDR_WIDTH];
  assign head_data    = writeQueueData[DATA_WIDTH-1:0];
  assign capture_now  = (state == READ_CAPTURE);
  assign more_writes  = (({1'b0, write_count} + 4'd1) < MAX_WRITES) && !writeQueueEmpty;

  // Slot sequencer: registered bus controls, pop strobe, busy and overrun flags.
  // busy also covers the cycle after the FSM returns to IDLE, so a slot
  // occupies 2P + 3W cycles and a new slotStart in that tail is an overrun.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state                 <= IDLE;
      pixel_idx             <= '0;
      write_count           <= '0;
      x_lat                 <= '0;
      y_lat                 <= '0;
      sramAddress           <= '0;
      sramDataOut           <= '0;
      sramDataOutEnable     <= 1'b0;
      sramOutputEnableN     <= 1'b1;
      sramWriteEnableN      <= 1'b1;
      pixelsValid           <= 1'b0;
      writeQueueReadRequest <= 1'b0;
      busy                  <= 1'b0;
      slotOverrun           <= 1'b0;
    end else begin
      pixelsValid           <= 1'b0;
      writeQueueReadRequest <= 1'b0;
      busy                  <= (state != IDLE);
      if (slotStart && busy) begin
        slotOverrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (slotStart && !busy) begin
            x_lat             <= readXCoord;
            y_lat             <= readYCoord;
            sramAddress       <= {readYCoord, readXCoord};
            sramOutputEnableN <= 1'b0;
            sramDataOutEnable <= 1'b0;
            pixel_idx         <= '0;
            busy              <= 1'b1;
            state             <= READ_CAPTURE;
          end
        end
        READ_CAPTURE: begin
          if ({1'b0, pixel_idx} < LAST_IDX) begin
            // X wraps within the row; Y stays fixed for the whole burst.
            sramAddress <= {y_lat, x_lat + X_WIDTH'(pixel_idx) + X_WIDTH'(1)};
            state       <= READ_ADDR;
          end else begin
            pixelsValid       <= 1'b1;
            sramOutputEnableN <= 1'b1;
            if (WRITES_ENABLED && !writeQueueEmpty) begin
              write_count           <= '0;
              sramAddress           <= head_address;
              sramDataOut           <= head_data;
              sramDataOutEnable     <= 1'b1;
              writeQueueReadRequest <= 1'b1;
              state                 <= WRITE_SETUP;
            end else begin
              state <= IDLE;
            end
          end
        end
        READ_ADDR: begin
          pixel_idx <= pixel_idx + 3'd1;
          state     <= READ_CAPTURE;
        end
        WRITE_SETUP: begin
          sramWriteEnableN <= 1'b0;
          state            <= WRITE_STROBE;
        end
        WRITE_STROBE: begin
          sramWriteEnableN <= 1'b1;
          state            <= WRITE_RELEASE;
        end
        WRITE_RELEASE: begin
          write_count <= write_count + 3'd1;
          if (more_writes) begin
            sramAddress           <= head_address;
            sramDataOut           <= head_data;
            sramDataOutEnable     <= 1'b1;
            sramOutputEnableN     <= 1'b1;
            writeQueueReadRequest <= 1'b1;
            state                 <= WRITE_SETUP;
          end else begin
            sramDataOutEnable <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel capture registers: slot i loads the SRAM bus when its read completes.
  for (genvar g = 0; g < PIXELS_PER_SLOT; g++) begin : g_pixel
    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        pixel_q[g] <= '0;
      end else if (capture_now && (pixel_idx == 3'(g))) begin
        pixel_q[g] <= sramDataIn;
      end
    end
    assign pixels[g*DATA_WIDTH +: DATA_WIDTH] = pixel_q[g];
  end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// tb/tb_sram_slot_arbiter.sv - directed self-checking bench for sram_slot_arbiter
module tb_sram_slot_arbiter;
  import sram_arbiter_pkg::*;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int DW = 8;
  localparam int P  = 2;
  localparam int AW = XW + YW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetN;
  logic start1, start2;
  logic [XW-1:0] xc;
  logic [YW-1:0] yc;

  logic [P*DW-1:0] pix1, pix2;
  logic pv1, pv2, emp1, emp2, rq1, rq2;
  logic [AW+DW-1:0] wq1, wq2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] din1, din2, dout1, dout2;
  logic doe1, doe2, oe1, oe2, we1, we2, busy1, busy2, ovr1, ovr2;

  int n_checks = 0;
  int n_fail = 0;
  int pop_err = 0;
  int inv_err = 0;

  pending_write_t fifo1 [16];
  pending_write_t fifo2 [16];
  int rd1 = 0, wr1 = 0, rd2 = 0, wr2 = 0;
  logic [AW-1:0] wa1 [$];
  logic [DW-1:0] wd1 [$];
  logic [AW-1:0] wa2 [$];
  logic [DW-1:0] wd2 [$];

  assign wq1  = fifo1[rd1 % 16];
  assign wq2  = fifo2[rd2 % 16];
  assign emp1 = (rd1 == wr1);
  assign emp2 = (rd2 == wr2);
  assign din1 = a1[7:0];
  assign din2 = a2[7:0];

  sram_slot_arbiter #(.X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW),
                      .PIXELS_PER_SLOT(P), .MAX_WRITES_PER_SLOT(1)) dut1 (
    .clock(clock), .resetN(resetN), .slotStart(start1),
    .readXCoord(xc), .readYCoord(yc), .pixels(pix1), .pixelsValid(pv1),
    .writeQueueData(wq1), .writeQueueEmpty(emp1), .writeQueueReadRequest(rq1),
    .sramAddress(a1), .sramDataIn(din1), .sramDataOut(dout1),
    .sramDataOutEnable(doe1), .sramOutputEnableN(oe1), .sramWriteEnableN(we1),
    .busy(busy1), .slotOverrun(ovr1));

  sram_slot_arbiter #(.X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW),
                      .PIXELS_PER_SLOT(P), .MAX_WRITES_PER_SLOT(2)) dut2 (
    .clock(clock), .resetN(resetN), .slotStart(start2),
    .readXCoord(xc), .readYCoord(yc), .pixels(pix2), .pixelsValid(pv2),
    .writeQueueData(wq2), .writeQueueEmpty(emp2), .writeQueueReadRequest(rq2),
    .sramAddress(a2), .sramDataIn(din2), .sramDataOut(dout2),
    .sramDataOutEnable(doe2), .sramOutputEnableN(oe2), .sramWriteEnableN(we2),
    .busy(busy2), .slotOverrun(ovr2));

  // FIFO models pop on the clock edge that ends the request cycle.
  always @(posedge clock) begin
    if (rq1) begin
      if (emp1) pop_err++;
      else rd1 <= rd1 + 1;
    end
    if (rq2) begin
      if (emp2) pop_err++;
      else rd2 <= rd2 + 1;
    end
  end

  // SRAM write log and bus invariant monitor, mid-cycle.
  always @(negedge clock) begin
    if (!we1) begin wa1.push_back(a1); wd1.push_back(dout1); end
    if (!we2) begin wa2.push_back(a2); wd2.push_back(dout2); end
    if (!oe1 && doe1) inv_err++;
    if (!oe2 && doe2) inv_err++;
    if (!we1 && !doe1) inv_err++;
    if (!we2 && !doe2) inv_err++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; start1 = 1'b0; start2 = 1'b0; xc = '0; yc = '0;
    repeat (3) tick();
    n_checks++; if (a1 !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", a1); end
    n_checks++; if (dout1 !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout1); end
    n_checks++; if ({doe1, oe1, we1} !== 3'b011) begin n_fail++; $display("FAIL reset_bus: got %b expected 011", {doe1, oe1, we1}); end
    n_checks++; if (pix1 !== '0) begin n_fail++; $display("FAIL reset_pixels: got %h expected 0", pix1); end
    n_checks++; if ({pv1, rq1, busy1, ovr1} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {pv1, rq1, busy1, ovr1}); end
    @(negedge clock);
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_read_basic();
    xc = 9'd5; yc = 8'd3;
    start1 = 1'b1; tick(); start1 = 1'b0;
    n_checks++; if (a1 !== {8'd3, 9'd5}) begin n_fail++; $display("FAIL rd_addr0: got %h expected %h", a1, {8'd3, 9'd5}); end
    n_checks++; if ({oe1, busy1} !== 2'b01) begin n_fail++; $display("FAIL rd_oe_busy: got %b expected 01", {oe1, busy1}); end
    tick();
    n_checks++; if (a1 !== {8'd3, 9'd6}) begin n_fail++; $display("FAIL rd_addr1: got %h expected %h", a1, {8'd3, 9'd6}); end
    tick(); tick();
    n_checks++; if (pv1 !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b expected 1", pv1); end
    n_checks++; if (pix1 !== 16'h0605) begin n_fail++; $display("FAIL rd_pixels: got %h expected 0605", pix1); end
    n_checks++; if ({oe1, busy1} !== 2'b11) begin n_fail++; $display("FAIL rd_end_oe_busy: got %b expected 11", {oe1, busy1}); end
    tick();
    n_checks++; if ({pv1, busy1} !== 2'b00) begin n_fail++; $display("FAIL rd_done: got %b expected 00", {pv1, busy1}); end
    n_checks++; if (wa1.size() !== 0) begin n_fail++; $display("FAIL rd_no_write: got %0d expected 0", wa1.size()); end
  endtask

  task automatic test_read_wrap();
    xc = 9'd511; yc = 8'd3;
    start1 = 1'b1; tick(); start1 = 1'b0;
    n_checks++; if (a1 !== {8'd3, 9'd511}) begin n_fail++; $display("FAIL wrap_addr0: got %h expected %h", a1, {8'd3, 9'd511}); end
    tick();
    n_checks++; if (a1 !== {8'd3, 9'd0}) begin n_fail++; $display("FAIL wrap_addr1: got %h expected %h", a1, {8'd3, 9'd0}); end
    tick(); tick();
    n_checks++; if (pix1 !== 16'h00FF) begin n_fail++; $display("FAIL wrap_pixels: got %h expected 00ff", pix1); end
    tick();
  endtask

  task automatic test_write_single();
    int len;
    fifo1[wr1 % 16] = '{address: 17'h01234, data: 8'hAB}; wr1++;
    fifo1[wr1 % 16] = '{address: 17'h00010, data: 8'hCD}; wr1++;
    wa1.delete(); wd1.delete();
    xc = '0; yc = '0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick(); tick();
    n_checks++; if ({a1, dout1} !== {17'h01234, 8'hAB}) begin n_fail++; $display("FAIL wr_setup_bus: got %h expected %h", {a1, dout1}, {17'h01234, 8'hAB}); end
    n_checks++; if ({doe1, oe1, we1, rq1} !== 4'b1111) begin n_fail++; $display("FAIL wr_setup_ctl: got %b expected 1111", {doe1, oe1, we1, rq1}); end
    tick();
    n_checks++; if ({we1, rq1, rd1} !== {2'b00, 32'd1}) begin n_fail++; $display("FAIL wr_strobe: got we=%b rq=%b rd=%0d expected 0 0 1", we1, rq1, rd1); end
    tick();
    n_checks++; if ({we1, doe1, a1} !== {2'b11, 17'h01234}) begin n_fail++; $display("FAIL wr_release: got %b %b %h expected 1 1 01234", we1, doe1, a1); end
    tick();
    n_checks++; if ({doe1, busy1} !== 2'b01) begin n_fail++; $display("FAIL wr_tail: got %b expected 01", {doe1, busy1}); end
    tick();
    n_checks++; if ((wa1.size() != 1) || (wa1[0] !== 17'h01234) || (wd1[0] !== 8'hAB) || busy1)
      begin n_fail++; $display("FAIL wr_single_log: got n=%0d busy=%b expected 1 write ab@01234 and idle", wa1.size(), busy1); end
    len = 0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    while (busy1 && len < 40) begin tick(); len++; end
    n_checks++; if (len !== 7) begin n_fail++; $display("FAIL wr_slot_len: got %0d expected 7", len); end
    n_checks++; if ((wa1.size() != 2) || (wa1[1] !== 17'h00010) || (wd1[1] !== 8'hCD) || !emp1)
      begin n_fail++; $display("FAIL wr_second_slot: got n=%0d empty=%b expected 2 writes and empty", wa1.size(), emp1); end
  endtask

  task automatic test_back_to_back();
    int len;
    fifo2[wr2 % 16] = '{address: 17'h01234, data: 8'hAB}; wr2++;
    fifo2[wr2 % 16] = '{address: 17'h00010, data: 8'hCD}; wr2++;
    wa2.delete(); wd2.delete();
    xc = 9'd7; yc = 8'd1;
    len = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    while (busy2 && len < 40) begin tick(); len++; end
    n_checks++; if (len !== 10) begin n_fail++; $display("FAIL b2b_slot_len: got %0d expected 10", len); end
    n_checks++; if ((wa2.size() != 2) || (rd2 != 2)) begin n_fail++; $display("FAIL b2b_counts: got writes=%0d pops=%0d expected 2 2", wa2.size(), rd2); end
    n_checks++; if ((wa2.size() == 2) && ({wa2[0], wd2[0], wa2[1], wd2[1]} !== {17'h01234, 8'hAB, 17'h00010, 8'hCD}))
      begin n_fail++; $display("FAIL b2b_data: got %h/%h %h/%h expected 01234/ab 00010/cd", wa2[0], wd2[0], wa2[1], wd2[1]); end
    n_checks++; if (pix2 !== 16'h0807) begin n_fail++; $display("FAIL b2b_pixels: got %h expected 0807", pix2); end
  endtask

  task automatic test_overrun();
    n_checks++; if (ovr1 !== 1'b0) begin n_fail++; $display("FAIL ovr_initial: got %b expected 0", ovr1); end
    xc = 9'd10; yc = 8'd1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    xc = 9'd100; start1 = 1'b1; tick(); start1 = 1'b0;
    n_checks++; if (ovr1 !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr1); end
    tick();
    n_checks++; if ({pv1, pix1} !== {1'b1, 16'h0B0A}) begin n_fail++; $display("FAIL ovr_seq: got %b %h expected 1 0b0a", pv1, pix1); end
    repeat (4) tick();
    n_checks++; if ({ovr1, busy1} !== 2'b10) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 10", {ovr1, busy1}); end
  endtask

  task automatic test_reset_mid_write();
    int len;
    fifo1[wr1 % 16] = '{address: 17'h0ABCD, data: 8'h5A}; wr1++;
    xc = '0; yc = '0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (4) tick();
    n_checks++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL rst_pre_strobe: got %b expected 0", we1); end
    #2 resetN = 1'b0;
    #1;
    n_checks++; if ({we1, doe1, oe1, busy1, ovr1} !== 5'b10100) begin n_fail++; $display("FAIL rst_async: got %b expected 10100", {we1, doe1, oe1, busy1, ovr1}); end
    n_checks++; if (a1 !== '0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", a1); end
    @(negedge clock);
    resetN = 1'b1;
    tick();
    xc = 9'd20; yc = 8'd2;
    len = 0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    while (busy1 && len < 40) begin tick(); len++; end
    n_checks++; if ({len, pix1} !== {32'd4, 16'h1514}) begin n_fail++; $display("FAIL rst_next_slot: got len=%0d pix=%h expected 4 1514", len, pix1); end
  endtask

  task automatic test_invariants();
    n_checks++; if (inv_err !== 0) begin n_fail++; $display("FAIL bus_invariant: got %0d violations expected 0", inv_err); end
    n_checks++; if (pop_err !== 0) begin n_fail++; $display("FAIL pop_when_empty: got %0d expected 0", pop_err); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_wrap();
    test_write_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid_write();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
